// File: rtl/lifo_port_arbiter.sv
// Round-robin arbiter that shares a single LIFO stack between N_REQ requesters.
// Tracks occupancy locally so overflow/underflow is rejected before reaching the stack.
module lifo_port_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned STACK_SIZE = 16,
  localparam int unsigned IdW       = $clog2(N_REQ),
  localparam int unsigned LvlW      = $clog2(STACK_SIZE) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_push,
  input  logic [N_REQ-1:0]           req_pop,
  input  logic [N_REQ*BUS_WIDTH-1:0] req_data,
  input  logic                       flush,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rsp_valid,
  output logic [IdW-1:0]             rsp_id,
  output logic [BUS_WIDTH-1:0]       rsp_data,
  output logic                       rsp_err,
  output logic [LvlW-1:0]            level,
  output logic                       full,
  output logic                       empty,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [BUS_WIDTH-1:0]       stk_data_in,
  input  logic [BUS_WIDTH-1:0]       stk_data_out,
  output logic                       stk_reset
);

  typedef enum logic [1:0] {StIdle, StIssue, StCooldown, StFlush} state_e;

  state_e               r_state;
  state_e               w_state_d;
  logic [IdW-1:0]       r_rr;
  logic [IdW-1:0]       r_id;
  logic                 r_push;
  logic                 r_err;
  logic [BUS_WIDTH-1:0] r_rsp_data;
  logic [BUS_WIDTH-1:0] r_stk_din;
  logic [LvlW-1:0]      r_level;

  logic                 w_any;
  logic [IdW-1:0]       w_win;
  logic [IdW-1:0]       w_cand;
  logic                 w_win_push;
  logic [BUS_WIDTH-1:0] w_win_data;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  // First requesting port at or after the round-robin pointer wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_rr;
    w_cand = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_cand = IdW'((int'(r_rr) + k) % int'(N_REQ));
      if (!w_any && (req_push[w_cand] || req_pop[w_cand])) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  // Push takes precedence when a port raises both requests.
  assign w_win_push = req_push[w_win];
  assign w_win_data = req_data[int'(w_win)*int'(BUS_WIDTH) +: BUS_WIDTH];

  assign w_push_ok = (r_state == StIssue) && r_push && (r_level < LvlW'(STACK_SIZE));
  assign w_pop_ok  = (r_state == StIssue) && !r_push && (r_level != '0);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StCooldown: begin
        if (flush)      w_state_d = StFlush;
        else if (w_any) w_state_d = StIssue;
        else            w_state_d = StIdle;
      end
      StIssue: w_state_d = StCooldown;
      StFlush: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_rr       <= '0;
      r_id       <= '0;
      r_push     <= 1'b0;
      r_err      <= 1'b0;
      r_rsp_data <= '0;
      r_stk_din  <= '0;
      r_level    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_state_d == StIssue) begin
        r_id   <= w_win;
        r_push <= w_win_push;
        r_rr   <= (w_win == IdW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
        if (w_win_push) r_stk_din <= w_win_data;
      end
      if (r_state == StIssue) begin
        r_err      <= !(w_push_ok || w_pop_ok);
        r_rsp_data <= w_pop_ok ? stk_data_out : '0;
      end
      if (r_state == StFlush) r_level <= '0;
      else if (w_push_ok)     r_level <= r_level + 1'b1;
      else if (w_pop_ok)      r_level <= r_level - 1'b1;
    end
  end

  always_comb begin
    gnt = '0;
    if (r_state == StIssue) gnt[r_id] = 1'b1;
  end

  assign rsp_valid   = (r_state == StCooldown);
  assign rsp_id      = rsp_valid ? r_id : '0;
  assign rsp_err     = rsp_valid && r_err;
  assign rsp_data    = rsp_valid ? r_rsp_data : '0;
  assign level       = r_level;
  assign full        = (r_level == LvlW'(STACK_SIZE));
  assign empty       = (r_level == '0);
  assign stk_push    = w_push_ok;
  assign stk_pop     = w_pop_ok;
  assign stk_data_in = r_stk_din;
  assign stk_reset   = !reset || (r_state == StFlush);

endmodule
